seq_rom_fetch: RTL and testbench

- Fetches command words from the sequence ROM (synchronous BRAM) on behalf of the sequencer FSM and decodes each word into the command/instruction fields the sequencer checks.
- Owns the ROM address counter, tracks the fixed BRAM read latency, and signals each valid word with a one-cycle ready pulse.
- Sits directly between the sequence ROM and sequencer_fsm.

---
 rtl/bus_sequencer_pkg.sv | 25 ++
 rtl/seq_lat_pipe.sv | 17 +
 rtl/seq_rom_fetch.sv | 85 ++++++++
 tb/tb_seq_rom_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer_pkg: shared types, word field positions and word decode for the sequence ROM
package bus_sequencer_pkg;
  localparam int CMD_BIT   = 31;
  localparam int INSTR_MSB = 30;
  localparam int INSTR_LSB = 28;
  localparam int DATA_MSB  = 15;
  typedef enum logic {RUN_TRANSFER = 1'b0, INSTRUCTION = 1'b1} cmd_t;
  typedef enum logic [2:0] {NOP = 3'd0, STOP = 3'd1, PAUSE = 3'd2, WAIT = 3'd3, CMP = 3'd4} instr_t;
  typedef logic [DATA_MSB:0] instr_data_t;
  typedef struct packed {
    cmd_t        cmd;
    instr_t      instr;
    instr_data_t data;
  } word_fields_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} fetch_state_t;
  function automatic word_fields_t decode_word(input logic [31:0] w);
    word_fields_t f;
    logic [2:0] op;
    op      = w[INSTR_MSB:INSTR_LSB];
    f.cmd   = cmd_t'(w[CMD_BIT]);
    f.instr = op > 3'd4 ? NOP : instr_t'(op);
    f.data  = w[DATA_MSB:0];
    return f;
  endfunction
endpackage

// File: rtl/seq_lat_pipe.sv
// seq_lat_pipe: valid shift register tracking the fixed ROM read latency, flushable on abort
module seq_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o
);
  logic [DEPTH-1:0] sr;
  // shift the issue marker toward the capture point; a flush kills everything in flight
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) sr <= '0;
    else sr <= flush_i ? '0 : (sr << 1) | DEPTH'(valid_i);
  assign valid_o = sr[DEPTH-1];
endmodule

// File: rtl/seq_rom_fetch.sv
// seq_rom_fetch: fetches sequence ROM words for the sequencer and decodes them into command fields
module seq_rom_fetch
  import bus_sequencer_pkg::*;
#(
  parameter int ROM_AW      = 10,
  parameter int ROM_DW      = 32,
  parameter int ROM_LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               load_start_addr_i,
  input  logic [ROM_AW-1:0]  start_addr_i,
  input  logic               read_next_i,
  output logic               rom_en_o,
  output logic [ROM_AW-1:0]  rom_addr_o,
  input  logic [ROM_DW-1:0]  rom_rdata_i,
  output logic               rom_data_rdy_o,
  output cmd_t               cmd_type_o,
  output instr_t             instr_type_o,
  output instr_data_t        instr_data_o,
  output logic [INSTR_MSB:0] xfer_word_o,
  output logic [ROM_AW-1:0]  cur_addr_o,
  output logic               busy_o,
  output logic               wrap_o,
  output logic               proto_err_o
);
  fetch_state_t      state;
  word_fields_t      dec;
  logic              lat_done;
  logic [ROM_AW-1:0] next_addr;
  assign next_addr = cur_addr_o + 1'b1;
  assign dec       = decode_word(rom_rdata_i);
  assign busy_o    = state != IDLE;
  seq_lat_pipe #(.DEPTH(ROM_LATENCY)) u_lat (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .flush_i (load_start_addr_i),
    .valid_i (rom_en_o),
    .valid_o (lat_done)
  );
  // fetch FSM: a load always restarts, read_next only launches from IDLE, capture when the latency marker arrives
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      state          <= IDLE;
      rom_en_o       <= 1'b0;
      rom_addr_o     <= '0;
      cur_addr_o     <= '0;
      rom_data_rdy_o <= 1'b0;
      cmd_type_o     <= RUN_TRANSFER;
      instr_type_o   <= NOP;
      instr_data_o   <= '0;
      xfer_word_o    <= '0;
      wrap_o         <= 1'b0;
      proto_err_o    <= 1'b0;
    end else begin
      rom_en_o       <= 1'b0;
      rom_data_rdy_o <= 1'b0;
      wrap_o         <= 1'b0;
      if (load_start_addr_i) begin
        state       <= ISSUE;
        rom_en_o    <= 1'b1;
        rom_addr_o  <= start_addr_i;
        cur_addr_o  <= start_addr_i;
        proto_err_o <= 1'b0;
      end else begin
        if (read_next_i && busy_o) proto_err_o <= 1'b1;
        if (state == IDLE && read_next_i) begin
          state      <= ISSUE;
          rom_en_o   <= 1'b1;
          rom_addr_o <= next_addr;
          cur_addr_o <= next_addr;
          wrap_o     <= next_addr == '0;
        end else if (state == ISSUE) begin
          state <= WAIT_DATA;
        end else if (state == WAIT_DATA && lat_done) begin
          state          <= IDLE;
          rom_data_rdy_o <= 1'b1;
          cmd_type_o     <= dec.cmd;
          instr_type_o   <= dec.instr;
          instr_data_o   <= dec.data;
          xfer_word_o    <= rom_rdata_i[INSTR_MSB:0];
        end
      end
    end
endmodule

// File: tb/tb_seq_rom_fetch.sv
// tb_seq_rom_fetch: scoreboard bench running three fetchers (latency 2, 1, 4) from one stimulus stream
module tb_seq_rom_fetch;
  import bus_sequencer_pkg::*;
  typedef struct {int t; logic [9:0] addr; logic w;} iss_t;
  typedef struct {int t; logic [9:0] addr; logic c; logic [2:0] ins; logic [15:0] d; logic [30:0] x;} rd_t;
  function automatic int lat_of(input int g);
    return g == 0 ? 2 : g == 1 ? 1 : 4;
  endfunction
  logic clk_i = 1'b0, nrst_i = 1'b0, load = 1'b0, rn = 1'b0;
  logic [9:0] start = '0;
  logic [31:0] rom [1024];
  logic rom_en [3], rdy [3], busy [3], wrap [3], perr [3];
  logic [9:0] rom_addr [3], cur [3];
  logic [31:0] rdata [3];
  logic [30:0] xfer [3];
  cmd_t cmd [3];
  instr_t instr [3];
  instr_data_t idata [3];
  int cyc = 0, n_chk = 0, n_err = 0, t_req = 0, n_wrap = 0;
  int ii [3] = '{0, 0, 0};
  int ri [3] = '{0, 0, 0};
  int wc [3] = '{0, 0, 0};
  iss_t iss_q [$];
  rd_t rd_q [$];
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : u
    logic [31:0] p [4];
    always @(posedge clk_i) begin
      p[0] <= rom_en[g] ? rom[rom_addr[g]] : 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) p[k] <= p[k-1];
    end
    assign rdata[g] = p[lat_of(g)-1];
    seq_rom_fetch #(.ROM_AW(10), .ROM_DW(32), .ROM_LATENCY(lat_of(g))) dut (
      .clk_i             (clk_i),
      .nrst_i            (nrst_i),
      .load_start_addr_i (load),
      .start_addr_i      (start),
      .read_next_i       (rn),
      .rom_en_o          (rom_en[g]),
      .rom_addr_o        (rom_addr[g]),
      .rom_rdata_i       (rdata[g]),
      .rom_data_rdy_o    (rdy[g]),
      .cmd_type_o        (cmd[g]),
      .instr_type_o      (instr[g]),
      .instr_data_o      (idata[g]),
      .xfer_word_o       (xfer[g]),
      .cur_addr_o        (cur[g]),
      .busy_o            (busy[g]),
      .wrap_o            (wrap[g]),
      .proto_err_o       (perr[g])
    );
  end
  function automatic void ck(input string n, input int g, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s dut%0d(lat %0d): got %h expected %h", n, g, lat_of(g), a, e);
    end
  endfunction
  always @(negedge clk_i)
    for (int g = 0; g < 3; g++) begin
      if (rom_en[g]) begin
        if (ii[g] < iss_q.size()) begin
          ck("issue_addr", g, 32'(rom_addr[g]), 32'(iss_q[ii[g]].addr));
          ck("issue_cycle", g, cyc, iss_q[ii[g]].t + 1);
          ck("issue_wrap", g, 32'(wrap[g]), 32'(iss_q[ii[g]].w));
        end
        ii[g]++;
      end
      if (wrap[g]) wc[g]++;
      if (rdy[g]) begin
        if (ri[g] < rd_q.size()) begin
          ck("rdy_cycle", g, cyc, rd_q[ri[g]].t + lat_of(g) + 2);
          ck("cmd", g, 32'(cmd[g]), 32'(rd_q[ri[g]].c));
          ck("instr", g, 32'(instr[g]), 32'(rd_q[ri[g]].ins));
          ck("instr_data", g, 32'(idata[g]), 32'(rd_q[ri[g]].d));
          ck("xfer_word", g, 32'(xfer[g]), 32'(rd_q[ri[g]].x));
          ck("cur_addr", g, 32'(cur[g]), 32'(rd_q[ri[g]].addr));
        end
        ri[g]++;
      end
    end
  task automatic pulse(input logic ld, input logic nx, input logic [9:0] a);
    @(posedge clk_i); #1;
    load = ld; rn = nx; start = a; t_req = cyc;
    @(posedge clk_i); #1;
    load = 1'b0; rn = 1'b0;
  endtask
  task automatic exp_iss(input logic [9:0] a, input logic w);
    iss_q.push_back('{t_req, a, w});
    if (w) n_wrap++;
  endtask
  task automatic exp_rd(input logic [9:0] a, input logic c, input logic [2:0] ins, input logic [15:0] d, input logic [30:0] x);
    rd_q.push_back('{t_req, a, c, ins, d, x});
  endtask
  task automatic settle();
    repeat (8) @(posedge clk_i);
    #1;
    for (int g = 0; g < 3; g++) ck("idle_busy", g, 32'(busy[g]), 0);
  endtask
  task automatic check_zero(input string n);
    for (int g = 0; g < 3; g++) begin
      ck({n, "_en"}, g, 32'(rom_en[g]), 0);
      ck({n, "_addr"}, g, 32'(rom_addr[g]), 0);
      ck({n, "_rdy"}, g, 32'(rdy[g]), 0);
      ck({n, "_cmd"}, g, 32'(cmd[g]), 0);
      ck({n, "_instr"}, g, 32'(instr[g]), 0);
      ck({n, "_data"}, g, 32'(idata[g]), 0);
      ck({n, "_xfer"}, g, 32'(xfer[g]), 0);
      ck({n, "_cur"}, g, 32'(cur[g]), 0);
      ck({n, "_busy"}, g, 32'(busy[g]), 0);
      ck({n, "_wrap"}, g, 32'(wrap[g]), 0);
      ck({n, "_perr"}, g, 32'(perr[g]), 0);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h5A5A_5A5A;
    rom[10'h010] = 32'h8000_0000;
    rom[10'h011] = 32'h9000_0000;
    rom[10'h012] = 32'hB000_0005;
    rom[10'h013] = 32'h1234_5678;
    rom[10'h3FF] = 32'hA000_0001;
    rom[10'h000] = 32'hC000_ABCD;
    rom[10'h050] = 32'hD000_0007;
    rom[10'h020] = 32'h8000_0020;
    rom[10'h040] = 32'hF000_0040;
    repeat (3) @(posedge clk_i);
    #1;
    check_zero("reset");
    @(negedge clk_i);
    nrst_i = 1'b1;
    pulse(1'b1, 1'b0, 10'h010);
    exp_iss(10'h010, 1'b0);
    exp_rd(10'h010, 1'b1, 3'd0, 16'h0000, 31'h0000_0000);
    for (int g = 0; g < 3; g++) ck("issue_busy", g, 32'(busy[g]), 1);
    settle();
    pulse(1'b0, 1'b1, 10'h000);
    exp_iss(10'h011, 1'b0);
    exp_rd(10'h011, 1'b1, 3'd1, 16'h0000, 31'h1000_0000);
    settle();
    pulse(1'b0, 1'b1, 10'h000);
    exp_iss(10'h012, 1'b0);
    exp_rd(10'h012, 1'b1, 3'd3, 16'h0005, 31'h3000_0005);
    settle();
    pulse(1'b0, 1'b1, 10'h000);
    exp_iss(10'h013, 1'b0);
    exp_rd(10'h013, 1'b0, 3'd1, 16'h5678, 31'h1234_5678);
    settle();
    pulse(1'b1, 1'b0, 10'h3FF);
    exp_iss(10'h3FF, 1'b0);
    exp_rd(10'h3FF, 1'b1, 3'd2, 16'h0001, 31'h2000_0001);
    settle();
    pulse(1'b0, 1'b1, 10'h000);
    exp_iss(10'h000, 1'b1);
    exp_rd(10'h000, 1'b1, 3'd4, 16'hABCD, 31'h4000_ABCD);
    settle();
    pulse(1'b1, 1'b0, 10'h050);
    exp_iss(10'h050, 1'b0);
    exp_rd(10'h050, 1'b1, 3'd0, 16'h0007, 31'h5000_0007);
    rn = 1'b1;
    @(posedge clk_i); #1;
    rn = 1'b0;
    settle();
    for (int g = 0; g < 3; g++) ck("perr_set", g, 32'(perr[g]), 1);
    pulse(1'b1, 1'b1, 10'h013);
    exp_iss(10'h013, 1'b0);
    exp_rd(10'h013, 1'b0, 3'd1, 16'h5678, 31'h1234_5678);
    settle();
    for (int g = 0; g < 3; g++) ck("perr_clr_load_wins", g, 32'(perr[g]), 0);
    pulse(1'b1, 1'b0, 10'h020);
    exp_iss(10'h020, 1'b0);
    pulse(1'b1, 1'b0, 10'h040);
    exp_iss(10'h040, 1'b0);
    exp_rd(10'h040, 1'b1, 3'd0, 16'h0040, 31'h7000_0040);
    settle();
    for (int g = 0; g < 3; g++) ck("perr_after_abort", g, 32'(perr[g]), 0);
    pulse(1'b1, 1'b0, 10'h010);
    exp_iss(10'h010, 1'b0);
    @(posedge clk_i); #2;
    nrst_i = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk_i);
    nrst_i = 1'b1;
    settle();
    pulse(1'b1, 1'b0, 10'h012);
    exp_iss(10'h012, 1'b0);
    exp_rd(10'h012, 1'b1, 3'd3, 16'h0005, 31'h3000_0005);
    settle();
    for (int g = 0; g < 3; g++) begin
      ck("issue_count", g, ii[g], iss_q.size());
      ck("rdy_count", g, ri[g], rd_q.size());
      ck("wrap_count", g, wc[g], n_wrap);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
